// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing store behind the cache memory port.
// Programmable command-acceptance stall and fixed read latency.
module mem_responder #(
    parameter int MEM_AW   = 12,
    parameter int WAIT_CYC = 2,
    parameter int RD_LAT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] i_addr,
    input  logic [3:0]  i_byte_en,
    input  logic [31:0] i_writedata,
    input  logic        i_read,
    input  logic        i_write,
    output logic [31:0] o_readdata,
    output logic        o_readdata_valid,
    output logic        o_waitrequest,
    output logic [31:0] cnt_rd,
    output logic [31:0] cnt_wr,
    output logic        err_both
);

    localparam int DEPTH = 1 << MEM_AW;
    localparam int WW    = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t              state_q;
    logic [WW-1:0]       wait_cnt_q;
    logic [3:0]          lat_cnt_q;
    logic [MEM_AW-1:0]   idx_q;
    logic [31:0]         rdata_q;
    logic                valid_q;
    logic [31:0]         cnt_rd_q;
    logic [31:0]         cnt_wr_q;
    logic                err_q;
    logic [31:0]         mem_q [0:DEPTH-1];

    logic                cmd;
    logic                at_limit;
    logic                accept;
    logic                wr_acc;
    logic [MEM_AW-1:0]   idx_d;
    logic                unused_addr;

    assign cmd      = i_read | i_write;
    assign at_limit = (wait_cnt_q == WW'(WAIT_CYC));
    assign accept   = cmd && (state_q == IDLE) && at_limit;
    assign wr_acc   = accept && i_write;
    // Byte-style address: low 3 bits dropped, upper bits alias modulo depth.
    assign idx_d    = i_addr[MEM_AW+2:3];
    assign unused_addr = ^{i_addr[25:MEM_AW+3], i_addr[2:0]};

    assign o_waitrequest    = cmd && !((state_q == IDLE) && at_limit);
    assign o_readdata       = rdata_q;
    assign o_readdata_valid = valid_q;
    assign cnt_rd           = cnt_rd_q;
    assign cnt_wr           = cnt_wr_q;
    assign err_both         = err_q;

    // Backing store: byte-lane writes on acceptance; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            for (int b = 0; b < 4; b++) begin
                if (i_byte_en[b]) begin
                    mem_q[idx_d][8*b +: 8] <= i_writedata[8*b +: 8];
                end
            end
        end
    end

    // Command FSM: stall counting, acceptance, read latency and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            lat_cnt_q  <= '0;
            idx_q      <= '0;
            rdata_q    <= '0;
            valid_q    <= 1'b0;
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!cmd) begin
                        wait_cnt_q <= '0;
                    end else if (!at_limit) begin
                        wait_cnt_q <= wait_cnt_q + WW'(1);
                    end else begin
                        wait_cnt_q <= '0;
                        if (i_write) begin
                            cnt_wr_q <= cnt_wr_q + 32'd1;
                            if (i_read) begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            cnt_rd_q <= cnt_rd_q + 32'd1;
                            idx_q    <= idx_d;
                            if (RD_LAT == 1) begin
                                rdata_q <= mem_q[idx_d];
                                valid_q <= 1'b1;
                            end else begin
                                lat_cnt_q <= 4'(RD_LAT - 1);
                                state_q   <= RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    wait_cnt_q <= '0;
                    // Response is registered, so launch it while lat_cnt
                    // is 1; valid is then seen in the cycle it reaches 0.
                    if (lat_cnt_q <= 4'd1) begin
                        lat_cnt_q <= '0;
                        rdata_q   <= mem_q[idx_q];
                        valid_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed vectors for mem_responder.
// Inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_mem_responder;

    localparam int WAIT_CYC = 2;
    localparam int RD_LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] i_addr;
    logic [3:0]  i_byte_en;
    logic [31:0] i_writedata;
    logic        i_read;
    logic        i_write;
    logic [31:0] o_readdata;
    logic        o_readdata_valid;
    logic        o_waitrequest;
    logic [31:0] cnt_rd;
    logic [31:0] cnt_wr;
    logic        err_both;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .MEM_AW  (12),
        .WAIT_CYC(WAIT_CYC),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_addr          (i_addr),
        .i_byte_en       (i_byte_en),
        .i_writedata     (i_writedata),
        .i_read          (i_read),
        .i_write         (i_write),
        .o_readdata      (o_readdata),
        .o_readdata_valid(o_readdata_valid),
        .o_waitrequest   (o_waitrequest),
        .cnt_rd          (cnt_rd),
        .cnt_wr          (cnt_wr),
        .err_both        (err_both)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present a command until accepted; ends 1ns into the cycle after
    // acceptance with the command withdrawn.
    task automatic present(input logic rd, input logic wr,
                           input logic [25:0] a, input logic [3:0] be,
                           input logic [31:0] d, input int exp_waits);
        int waits;
        logic ok;
        waits = 0;
        ok = 1'b0;
        @(posedge clk); #1;
        i_read      = rd;
        i_write     = wr;
        i_addr      = a;
        i_byte_en   = be;
        i_writedata = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!o_waitrequest) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        check("accepted", 32'(ok), 32'd1);
        check("wait_cycles", 32'(waits), 32'(exp_waits));
        @(posedge clk); #1;
        i_read  = 1'b0;
        i_write = 1'b0;
    endtask

    task automatic read_expect(input logic [25:0] a, input logic [31:0] exp);
        present(1'b1, 1'b0, a, 4'h0, 32'h0, WAIT_CYC);
        for (int k = 1; k <= RD_LAT + 1; k++) begin
            @(negedge clk);
            check("rd_valid", 32'(o_readdata_valid), 32'(k == RD_LAT));
            if (k >= RD_LAT) check("rd_data", o_readdata, exp);
        end
    endtask

    task automatic no_valid(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("no_valid", 32'(o_readdata_valid), 32'd0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        i_addr      = '0;
        i_byte_en   = '0;
        i_writedata = '0;
        i_read      = 1'b0;
        i_write     = 1'b0;
        do_reset();

        @(negedge clk);
        check("rst_valid", 32'(o_readdata_valid), 32'd0);
        check("rst_rdata", o_readdata, 32'd0);
        check("rst_cnt_rd", cnt_rd, 32'd0);
        check("rst_cnt_wr", cnt_wr, 32'd0);
        check("rst_err", 32'(err_both), 32'd0);
        check("idle_wreq", 32'(o_waitrequest), 32'd0);

        // Full-word write with two stall cycles
        present(1'b0, 1'b1, 26'h10, 4'hF, 32'hDEADBEEF, WAIT_CYC);
        check("wr1_cnt_wr", cnt_wr, 32'd1);
        no_valid(3);

        // Read back with fixed latency, data then holds
        read_expect(26'h10, 32'hDEADBEEF);
        check("rd1_cnt_rd", cnt_rd, 32'd1);

        // Partial byte-lane merge
        present(1'b0, 1'b1, 26'h10, 4'b0101, 32'h11223344, WAIT_CYC);
        read_expect(26'h10, 32'hDE22BE44);

        // Write presented while a read is outstanding
        present(1'b0, 1'b1, 26'h20, 4'hF, 32'hCAFEF00D, WAIT_CYC);
        present(1'b1, 1'b0, 26'h20, 4'h0, 32'h0, WAIT_CYC);
        i_write     = 1'b1;
        i_addr      = 26'h20;
        i_byte_en   = 4'hF;
        i_writedata = 32'h12345678;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("rdw_wreq", 32'(o_waitrequest), 32'(k < 6));
            check("rdw_valid", 32'(o_readdata_valid), 32'(k == 4));
            if (k == 4) check("rdw_old_data", o_readdata, 32'hCAFEF00D);
        end
        @(posedge clk); #1;
        i_write = 1'b0;
        check("rdw_cnt_wr", cnt_wr, 32'd4);
        read_expect(26'h20, 32'h12345678);

        // Read and write together: write wins, sticky error
        do_reset();
        present(1'b1, 1'b1, 26'h40, 4'hF, 32'h5, WAIT_CYC);
        no_valid(6);
        check("both_err", 32'(err_both), 32'd1);
        check("both_cnt_wr", cnt_wr, 32'd1);
        check("both_cnt_rd", cnt_rd, 32'd0);
        read_expect(26'h40, 32'h5);
        check("both_err_hold", 32'(err_both), 32'd1);

        // Reset during RD_WAIT drops the read
        present(1'b1, 1'b0, 26'h40, 4'h0, 32'h0, WAIT_CYC);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        no_valid(6);
        check("rstrd_cnt_rd", cnt_rd, 32'd0);
        check("rstrd_cnt_wr", cnt_wr, 32'd0);
        check("rstrd_err", 32'(err_both), 32'd0);
        read_expect(26'h40, 32'h5);

        // Address aliasing and ignored low bits
        present(1'b0, 1'b1, 26'h8008, 4'hF, 32'hA5A50001, WAIT_CYC);
        present(1'b0, 1'b1, 26'h0, 4'hF, 32'h0BADF00D, WAIT_CYC);
        read_expect(26'h0008, 32'hA5A50001);
        read_expect(26'h000C, 32'hA5A50001);
        read_expect(26'h8008, 32'hA5A50001);
        read_expect(26'h1000000, 32'h0BADF00D);
        check("end_cnt_rd", cnt_rd, 32'd5);
        check("end_cnt_wr", cnt_wr, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
